// File: rtl/arb_pkg.sv
// Shared constants and types for the data-memory port arbiter.
// Build with ARB_LOCK_EN defined to add the per-core lock input.
package arb_pkg;

    localparam int NUM_CORES_DEF = 4;
    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int RD_LAT_DEF    = 2;

    localparam int ID_W = $clog2(NUM_CORES_DEF);

    typedef logic [ID_W-1:0] core_id_t;

    typedef struct packed {
        logic     valid;
        core_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate request vector by the pointer,
// priority-encode, then map the winner back to its real index.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] win_id,
    output logic            any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             idx;

    always_comb begin
        gnt    = '0;
        win_id = '0;
        any    = 1'b0;
        idx    = 0;
        dbl    = {req, req} >> rr_ptr;
        rot    = dbl[N-1:0];
        for (int k = 0; k < N; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                idx = int'(rr_ptr) + k;
                if (idx >= N) idx = idx - N;
                win_id   = ID_W'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among cores,
// with fixed-latency read tag tracking. Optional macro: ARB_LOCK_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_CORES-1:0]        lock,
`endif
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int LW = $clog2(NUM_CORES);

    logic [LW-1:0]        rr_ptr;
    logic [NUM_CORES-1:0] req_eff;
    logic [NUM_CORES-1:0] pick_gnt;
    logic [LW-1:0]        win_id;
    logic                 any;
    logic                 xfer;

    logic [RD_LAT-1:0]    tag_v;
    logic [LW-1:0]        tag_id [RD_LAT];

`ifdef ARB_LOCK_EN
    logic          locked;
    logic [LW-1:0] owner;

    // While locked, only the owner's lane is visible to the picker.
    always_comb begin
        req_eff = req;
        if (locked) begin
            req_eff        = '0;
            req_eff[owner] = req[owner];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= 1'b0;
            owner  <= '0;
        end else if (xfer) begin
            locked <= lock[win_id];
            owner  <= win_id;
        end
    end
`else
    assign req_eff = req;
`endif

    rr_pick #(
        .N    (NUM_CORES),
        .ID_W (LW)
    ) u_pick (
        .req    (req_eff),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .win_id (win_id),
        .any    (any)
    );

    // No grants while reset is held, so nothing is accepted then.
    assign xfer = any && !reset;

    always_comb begin
        gnt       = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (xfer) begin
            gnt       = pick_gnt;
            mem_en    = 1'b1;
            mem_we    = we[win_id];
            mem_addr  = addr[win_id*ADDR_W +: ADDR_W];
            mem_wdata = wdata[win_id*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            if (win_id == LW'(NUM_CORES - 1)) rr_ptr <= '0;
            else rr_ptr <= win_id + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_v[0]  <= xfer && !mem_we;
            tag_id[0] <= win_id;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (tag_v[RD_LAT-1]) rvalid[tag_id[RD_LAT-1]] = 1'b1;
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default build, RD_LAT=2)
// with a two-stage memory model driving mem_rdata.
module tb_mem_port_arbiter;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [NC-1:0]  req;
    logic [NC-1:0]  we;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [NC-1:0]  gnt;
    logic [NC-1:0]  rvalid;
    logic [DW-1:0]  rdata;
    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    logic [DW-1:0]  d0, d1;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) d0 <= mem_f(mem_addr);
        else d0 <= '0;
        d1 <= d0;
    end
    assign mem_rdata = d1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req   = '0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    logic [NC-1:0] exp_g [8];

    initial begin
        d0    = '0;
        d1    = '0;
        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        #1;

        // Reset then idle
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 32'h0);
            chk("idle_en", 32'(mem_en), 32'h0);
            chk("idle_rvalid", 32'(rvalid), 32'h0);
            chk("idle_addr", 32'(mem_addr), 32'h0);
            tick();
        end

        // Single read, core 2
        addr[2*AW +: AW] = 16'h0040;
        we  = '0;
        req = 4'b0100;
        @(negedge clk);
        chk("rd_gnt", 32'(gnt), 32'h4);
        chk("rd_en", 32'(mem_en), 32'h1);
        chk("rd_we", 32'(mem_we), 32'h0);
        chk("rd_addr", 32'(mem_addr), 32'h0040);
        tick();
        req = '0;
        @(negedge clk);
        chk("rd_t1_rvalid", 32'(rvalid), 32'h0);
        tick();
        @(negedge clk);
        chk("rd_t2_rvalid", 32'(rvalid), 32'h4);
        chk("rd_t2_rdata", 32'(rdata), 32'hBEEF);
        tick();
        @(negedge clk);
        chk("rd_t3_rvalid", 32'(rvalid), 32'h0);

        // All-request fairness (writes)
        tick();
        do_reset(1);
        for (int i = 0; i < NC; i++)
            wdata[i*DW +: DW] = DW'(16'h1000 + i);
        we  = 4'b1111;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("fair_gnt", 32'(gnt), 32'(1 << (k % 4)));
            chk("fair_we", 32'(mem_we), 32'h1);
            chk("fair_wdata", 32'(mem_wdata), 32'(16'h1000 + k % 4));
            chk("fair_rvalid", 32'(rvalid), 32'h0);
            tick();
        end
        req = '0;
        we  = '0;

        // Pipelined alternating reads, cores 1 and 3
        do_reset(1);
        addr[1*AW +: AW] = 16'h0011;
        addr[3*AW +: AW] = 16'h0033;
        req = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) exp_g[k] = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            else exp_g[k] = 4'b0000;
            @(negedge clk);
            chk("pipe_gnt", 32'(gnt), 32'(exp_g[k]));
            if (k >= RL) begin
                chk("pipe_rvalid", 32'(rvalid), 32'(exp_g[k-RL]));
                if (exp_g[k-RL] == 4'b0010)
                    chk("pipe_rdata", 32'(rdata), 32'(mem_f(16'h0011)));
                else
                    chk("pipe_rdata", 32'(rdata), 32'(mem_f(16'h0033)));
            end else begin
                chk("pipe_rvalid0", 32'(rvalid), 32'h0);
            end
            tick();
            if (k == 5) req = '0;
        end

        // Mid-flight reset after a core 0 read
        do_reset(1);
        addr[0*AW +: AW] = 16'h0005;
        req = 4'b0001;
        @(negedge clk);
        chk("mfr_gnt0", 32'(gnt), 32'h1);
        tick();
        req   = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("mfr_rst_rvalid", 32'(rvalid), 32'h0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mfr_rvalid", 32'(rvalid), 32'h0);
            tick();
        end
        req = 4'b1010;
        @(negedge clk);
        chk("mfr_first_gnt", 32'(gnt), 32'h2);
        tick();
        req = '0;

        // Reset after a core 2 read: pointer must return to 0
        addr[2*AW +: AW] = 16'h0040;
        req = 4'b0100;
        @(negedge clk);
        chk("mfr2_gnt2", 32'(gnt), 32'h4);
        tick();
        req   = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b1010;
        @(negedge clk);
        chk("mfr2_first_gnt", 32'(gnt), 32'h2);
        chk("mfr2_rvalid", 32'(rvalid), 32'h0);
        tick();
        req = '0;
        @(negedge clk);
        chk("mfr2_rvalid_late", 32'(rvalid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
